// File: rtl/race_ctrl_multi.sv
// Race sequencing FSM for NUM_CARS independently steered cars.
// It owns the car positions and drives one shared pixel drawer through request/done handshakes.
module race_ctrl_multi #(
    parameter int unsigned NUM_CARS = 2,
    parameter int unsigned SEL_W    = 2,
    parameter int unsigned X_W      = 8,
    parameter int unsigned Y_W      = 7,
    parameter int unsigned X_MIN    = 16,
    parameter int unsigned X_MAX    = 136,
    parameter int unsigned X_STEP   = 8,
    parameter int unsigned LANE_SP  = 32,
    parameter int unsigned Y_START  = 100
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [NUM_CARS-1:0] btn_left,
    input  logic [NUM_CARS-1:0] btn_right,
    input  logic [NUM_CARS-1:0] btn_straight,
    input  logic                frame_tick,
    input  logic                done_bg,
    input  logic                done_draw,
    input  logic                done_erase,
    output logic                draw_bg,
    output logic                draw_car,
    output logic                erase_car,
    output logic [SEL_W-1:0]    car_sel,
    output logic [X_W-1:0]      car_x,
    output logic [Y_W-1:0]      car_y,
    output logic                resetsignal,
    output logic                race_active,
    output logic                finished,
    output logic [SEL_W-1:0]    winner,
    output logic                frame_overrun
);

    typedef enum logic [3:0] {
        S_RESET_SIG, S_IDLE, S_DRAW_BG, S_DRAW_ALL, S_WAIT_FRAME,
        S_SCAN, S_ERASE, S_UPDATE, S_REDRAW, S_CHECK, S_FINISH
    } state_e;

    state_e                          state_q, state_d;
    logic [SEL_W-1:0]                car_sel_q, car_sel_d;
    logic [SEL_W-1:0]                winner_q, winner_d;
    logic [NUM_CARS-1:0][X_W-1:0]    x_q, x_d;
    logic [NUM_CARS-1:0][Y_W-1:0]    y_q, y_d;
    logic [NUM_CARS-1:0]             pl_q, pl_d, pr_q, pr_d;
    logic [NUM_CARS-1:0]             ml_q, ml_d, mr_q, mr_d, ms_q, ms_d;
    logic [NUM_CARS-1:0]             bl_q, bl_qq, br_q, br_qq;
    logic [NUM_CARS-1:0]             rise_l, rise_r;
    logic                            draw_bg_q, draw_car_q, erase_car_q;
    logic                            resetsignal_q, race_active_q, finished_q, overrun_q;

    logic [X_W-1:0] sel_x, nx;
    logic [Y_W-1:0] sel_y, ny;
    logic           sel_l, sel_r, sel_s, has_move, last_car, any_fin, in_race;
    logic [SEL_W-1:0] win_idx;

    assign rise_l   = bl_q & ~bl_qq;
    assign rise_r   = br_q & ~br_qq;
    assign last_car = (car_sel_q == SEL_W'(NUM_CARS - 1));
    assign in_race  = (state_q != S_RESET_SIG) && (state_q != S_IDLE);

    // Selected car's position and the saturated position its snapshot move would produce.
    always_comb begin
        sel_x = x_q[0];
        sel_y = y_q[0];
        sel_l = ml_q[0];
        sel_r = mr_q[0];
        sel_s = ms_q[0];
        for (int i = 0; i < NUM_CARS; i++) begin
            if (car_sel_q == SEL_W'(i)) begin
                sel_x = x_q[i];
                sel_y = y_q[i];
                sel_l = ml_q[i];
                sel_r = mr_q[i];
                sel_s = ms_q[i];
            end
        end
        nx = sel_x;
        if (sel_l && !sel_r) begin
            nx = (sel_x < X_W'(X_MIN + X_STEP)) ? X_W'(X_MIN) : sel_x - X_W'(X_STEP);
        end else if (sel_r && !sel_l) begin
            nx = (sel_x > X_W'(X_MAX - X_STEP)) ? X_W'(X_MAX) : sel_x + X_W'(X_STEP);
        end
        ny       = (sel_s && (sel_y != '0)) ? sel_y - Y_W'(1) : sel_y;
        has_move = (nx != sel_x) || (ny != sel_y);
    end

    // Lowest-index car sitting on the finish line.
    always_comb begin
        any_fin = 1'b0;
        win_idx = '0;
        for (int i = NUM_CARS - 1; i >= 0; i--) begin
            if (y_q[i] == '0) begin
                any_fin = 1'b1;
                win_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        car_sel_d = car_sel_q;
        winner_d  = winner_q;
        x_d       = x_q;
        y_d       = y_q;
        pl_d      = pl_q | rise_l;
        pr_d      = pr_q | rise_r;
        ml_d      = ml_q;
        mr_d      = mr_q;
        ms_d      = ms_q;
        unique case (state_q)
            S_RESET_SIG: state_d = S_IDLE;
            S_IDLE: begin
                if (start) begin
                    for (int i = 0; i < NUM_CARS; i++) begin
                        x_d[i] = X_W'(X_MIN + i * LANE_SP);
                        y_d[i] = Y_W'(Y_START);
                    end
                    pl_d     = '0;
                    pr_d     = '0;
                    winner_d = '0;
                    state_d  = S_DRAW_BG;
                end
            end
            S_DRAW_BG: begin
                if (done_bg) begin
                    car_sel_d = '0;
                    state_d   = S_DRAW_ALL;
                end
            end
            S_DRAW_ALL: begin
                if (done_draw) begin
                    if (last_car) state_d = S_WAIT_FRAME;
                    else          car_sel_d = car_sel_q + SEL_W'(1);
                end
            end
            S_WAIT_FRAME: begin
                if (frame_tick) begin
                    ml_d      = pl_q | rise_l;
                    mr_d      = pr_q | rise_r;
                    ms_d      = btn_straight;
                    pl_d      = '0;
                    pr_d      = '0;
                    car_sel_d = '0;
                    state_d   = S_SCAN;
                end
            end
            S_SCAN: begin
                if (has_move)      state_d = S_ERASE;
                else if (last_car) state_d = S_CHECK;
                else               car_sel_d = car_sel_q + SEL_W'(1);
            end
            S_ERASE: if (done_erase) state_d = S_UPDATE;
            S_UPDATE: begin
                for (int i = 0; i < NUM_CARS; i++) begin
                    if (car_sel_q == SEL_W'(i)) begin
                        x_d[i] = nx;
                        y_d[i] = ny;
                    end
                end
                state_d = S_REDRAW;
            end
            S_REDRAW: begin
                if (done_draw) begin
                    if (last_car) state_d = S_CHECK;
                    else begin
                        car_sel_d = car_sel_q + SEL_W'(1);
                        state_d   = S_SCAN;
                    end
                end
            end
            S_CHECK: begin
                if (any_fin) begin
                    winner_d = win_idx;
                    state_d  = S_FINISH;
                end else begin
                    state_d = S_WAIT_FRAME;
                end
            end
            S_FINISH: state_d = S_FINISH;
            default:  state_d = S_RESET_SIG;
        endcase
        // Dropping start abandons the race and any outstanding handshake.
        if (in_race && !start) state_d = S_RESET_SIG;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_RESET_SIG;
            car_sel_q     <= '0;
            winner_q      <= '0;
            for (int i = 0; i < NUM_CARS; i++) begin
                x_q[i] <= X_W'(X_MIN + i * LANE_SP);
                y_q[i] <= Y_W'(Y_START);
            end
            pl_q          <= '0;
            pr_q          <= '0;
            ml_q          <= '0;
            mr_q          <= '0;
            ms_q          <= '0;
            bl_q          <= '0;
            bl_qq         <= '0;
            br_q          <= '0;
            br_qq         <= '0;
            draw_bg_q     <= 1'b0;
            draw_car_q    <= 1'b0;
            erase_car_q   <= 1'b0;
            resetsignal_q <= 1'b1;
            race_active_q <= 1'b0;
            finished_q    <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            car_sel_q     <= car_sel_d;
            winner_q      <= winner_d;
            x_q           <= x_d;
            y_q           <= y_d;
            pl_q          <= pl_d;
            pr_q          <= pr_d;
            ml_q          <= ml_d;
            mr_q          <= mr_d;
            ms_q          <= ms_d;
            bl_q          <= btn_left;
            bl_qq         <= bl_q;
            br_q          <= btn_right;
            br_qq         <= br_q;
            draw_bg_q     <= (state_d == S_DRAW_BG);
            draw_car_q    <= (state_d == S_DRAW_ALL) || (state_d == S_REDRAW);
            erase_car_q   <= (state_d == S_ERASE);
            resetsignal_q <= (state_d == S_RESET_SIG);
            race_active_q <= (state_d != S_RESET_SIG) && (state_d != S_IDLE);
            finished_q    <= (state_d == S_FINISH);
            overrun_q     <= frame_tick && (state_q != S_WAIT_FRAME);
        end
    end

    assign draw_bg       = draw_bg_q;
    assign draw_car      = draw_car_q;
    assign erase_car     = erase_car_q;
    assign car_sel       = car_sel_q;
    assign car_x         = sel_x;
    assign car_y         = sel_y;
    assign resetsignal   = resetsignal_q;
    assign race_active   = race_active_q;
    assign finished      = finished_q;
    assign winner        = winner_q;
    assign frame_overrun = overrun_q;

endmodule

// File: tb/tb_race_ctrl_multi.sv
// Bench for race_ctrl_multi: vector table for the start-up sequence, then
// hand-written frames with a responsive drawer model for the multi-cycle cases.
module tb_race_ctrl_multi;

    logic       clock, reset, start;
    logic [1:0] btn_left, btn_right, btn_straight;
    logic       frame_tick, done_bg, done_draw, done_erase;
    logic       draw_bg, draw_car, erase_car;
    logic [1:0] car_sel, winner;
    logic [7:0] car_x;
    logic [6:0] car_y;
    logic       resetsignal, race_active, finished, frame_overrun;

    int passed = 0;
    int total  = 0;

    logic [18:0] ev [32];
    int          ev_n;

    race_ctrl_multi dut (
        .clock(clock), .reset(reset), .start(start),
        .btn_left(btn_left), .btn_right(btn_right), .btn_straight(btn_straight),
        .frame_tick(frame_tick), .done_bg(done_bg), .done_draw(done_draw),
        .done_erase(done_erase), .draw_bg(draw_bg), .draw_car(draw_car),
        .erase_car(erase_car), .car_sel(car_sel), .car_x(car_x), .car_y(car_y),
        .resetsignal(resetsignal), .race_active(race_active), .finished(finished),
        .winner(winner), .frame_overrun(frame_overrun)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [4:0]  in;   // start, done_bg, done_draw, done_erase, frame_tick
        logic [23:0] ex;
    } vec_t;

    function automatic logic [23:0] o(input logic bg, input logic dc, input logic er,
                                      input logic [1:0] s, input logic [7:0] x,
                                      input logic [6:0] y, input logic rs, input logic ra,
                                      input logic fi, input logic ov);
        return {bg, dc, er, s, x, y, rs, ra, fi, ov};
    endfunction

    function automatic logic [23:0] outvec();
        return {draw_bg, draw_car, erase_car, car_sel, car_x, car_y,
                resetsignal, race_active, finished, frame_overrun};
    endfunction

    function automatic logic [18:0] mk(input logic [1:0] k, input logic [1:0] s,
                                       input logic [7:0] x, input logic [6:0] y);
        return {k, s, x, y};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    // Drawer model: answers every request one cycle after seeing it and logs car draws/erases.
    task automatic service(input int cycles, input bit ovr, input bit abort);
        int ph;
        ph = 0;
        for (int c = 0; c < cycles; c++) begin
            done_bg = 0; done_draw = 0; done_erase = 0; frame_tick = 0;
            if (ph == 1) begin check("overrun_pulse", 32'(frame_overrun), 32'd1); ph = 2; end
            else if (ph == 2) begin check("overrun_clear", 32'(frame_overrun), 32'd0); ph = 3; end
            if (draw_bg) done_bg = 1;
            if (draw_car) begin
                if (ev_n < 32) ev[ev_n] = mk(2'd1, car_sel, car_x, car_y);
                ev_n++;
                done_draw = 1;
                if (ovr && ph == 0) begin frame_tick = 1; ph = 1; end
            end
            if (erase_car) begin
                if (ev_n < 32) ev[ev_n] = mk(2'd2, car_sel, car_x, car_y);
                ev_n++;
                if (abort) begin
                    start = 0;
                    step();
                    break;
                end
                done_erase = 1;
            end
            step();
        end
        done_bg = 0; done_draw = 0; done_erase = 0; frame_tick = 0;
    endtask

    task automatic run_frame(input logic [1:0] l, input logic [1:0] r, input logic [1:0] s,
                             input bit ovr, input bit abort, input int cyc);
        ev_n = 0;
        btn_left = l; btn_right = r;
        step(); step();
        btn_left = 0; btn_right = 0;
        step(); step();
        btn_straight = s; frame_tick = 1;
        step();
        btn_straight = 0; frame_tick = 0;
        service(cyc, ovr, abort);
    endtask

    task automatic check_events(input string name, input int n,
                                input logic [18:0] e0, input logic [18:0] e1,
                                input logic [18:0] e2, input logic [18:0] e3);
        logic [18:0] exp [4];
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
        check({name, "_count"}, 32'(ev_n), 32'(n));
        for (int i = 0; i < n && i < ev_n; i++)
            check($sformatf("%s_ev%0d", name, i), 32'(ev[i]), 32'(exp[i]));
    endtask

    vec_t tbl [12];

    initial begin
        reset = 1; start = 0; btn_left = 0; btn_right = 0; btn_straight = 0;
        frame_tick = 0; done_bg = 0; done_draw = 0; done_erase = 0; ev_n = 0;

        tbl[0]  = '{5'b10000, o(0,0,0,2'd0,8'd16,7'd100,0,0,0,0)};
        tbl[1]  = '{5'b10000, o(1,0,0,2'd0,8'd16,7'd100,0,1,0,0)};
        tbl[2]  = '{5'b10100, o(1,0,0,2'd0,8'd16,7'd100,0,1,0,0)};
        tbl[3]  = '{5'b11000, o(0,1,0,2'd0,8'd16,7'd100,0,1,0,0)};
        tbl[4]  = '{5'b10100, o(0,1,0,2'd1,8'd48,7'd100,0,1,0,0)};
        tbl[5]  = '{5'b10100, o(0,0,0,2'd1,8'd48,7'd100,0,1,0,0)};
        tbl[6]  = '{5'b10010, o(0,0,0,2'd1,8'd48,7'd100,0,1,0,0)};
        tbl[7]  = '{5'b10001, o(0,0,0,2'd0,8'd16,7'd100,0,1,0,0)};
        tbl[8]  = '{5'b10001, o(0,0,0,2'd1,8'd48,7'd100,0,1,0,1)};
        tbl[9]  = '{5'b10000, o(0,0,0,2'd1,8'd48,7'd100,0,1,0,0)};
        tbl[10] = '{5'b10000, o(0,0,0,2'd1,8'd48,7'd100,0,1,0,0)};
        tbl[11] = '{5'b10100, o(0,0,0,2'd1,8'd48,7'd100,0,1,0,0)};

        step(); step(); step();
        check("reset_state", 32'(outvec()), 32'(o(0,0,0,2'd0,8'd16,7'd100,1,0,0,0)));
        check("reset_winner", 32'(winner), 32'd0);
        reset = 0;

        for (int i = 0; i < 12; i++) begin
            {start, done_bg, done_draw, done_erase, frame_tick} = tbl[i].in;
            step();
            check($sformatf("vec%0d", i), 32'(outvec()), 32'(tbl[i].ex));
        end
        done_draw = 0;

        run_frame(2'b00, 2'b00, 2'b01, 0, 0, 40);
        check_events("car0_straight", 2, mk(2,0,16,100), mk(1,0,16,99), '0, '0);
        run_frame(2'b00, 2'b00, 2'b01, 1, 0, 40);
        check_events("overrun_frame", 2, mk(2,0,16,99), mk(1,0,16,98), '0, '0);
        run_frame(2'b01, 2'b01, 2'b00, 0, 0, 40);
        check_events("left_right_same", 0, '0, '0, '0, '0);
        run_frame(2'b01, 2'b00, 2'b00, 0, 0, 40);
        check_events("left_clamp", 0, '0, '0, '0, '0);

        for (int f = 0; f < 9; f++) run_frame(2'b00, 2'b10, 2'b00, 0, 0, 40);
        check_events("car1_to_120", 2, mk(2,1,112,100), mk(1,1,120,100), '0, '0);
        run_frame(2'b00, 2'b10, 2'b00, 0, 0, 40);
        check_events("car1_128", 2, mk(2,1,120,100), mk(1,1,128,100), '0, '0);
        run_frame(2'b00, 2'b10, 2'b00, 0, 0, 40);
        check_events("car1_136", 2, mk(2,1,128,100), mk(1,1,136,100), '0, '0);
        run_frame(2'b00, 2'b10, 2'b00, 0, 0, 40);
        check_events("car1_clamped", 0, '0, '0, '0, '0);

        run_frame(2'b00, 2'b00, 2'b10, 0, 0, 40);
        run_frame(2'b00, 2'b00, 2'b10, 0, 0, 40);
        check_events("car1_to_98", 2, mk(2,1,136,99), mk(1,1,136,98), '0, '0);
        for (int f = 0; f < 98; f++) begin
            if (f == 97) check("not_finished_at_y1", 32'(finished), 32'd0);
            run_frame(2'b00, 2'b00, 2'b11, 0, 0, 40);
        end
        check_events("last_frame", 4, mk(2,0,16,1), mk(1,0,16,0), mk(2,1,136,1), mk(1,1,136,0));
        check("finish_flags", 32'({finished, race_active}), 32'b11);
        check("winner_lowest", 32'(winner), 32'd0);

        start = 0;
        step();
        check("finish_exit", 32'({resetsignal, finished, race_active}), 32'b100);
        step();
        check("idle_after_exit", 32'({resetsignal, race_active}), 32'b00);

        start = 1;
        ev_n = 0;
        service(20, 0, 0);
        check_events("restart_draw", 2, mk(1,0,16,100), mk(1,1,48,100), '0, '0);
        run_frame(2'b00, 2'b00, 2'b11, 0, 0, 40);
        check_events("both_move", 4, mk(2,0,16,100), mk(1,0,16,99), mk(2,1,48,100), mk(1,1,48,99));
        run_frame(2'b00, 2'b00, 2'b01, 0, 1, 40);
        check("abort_rs", 32'({resetsignal, erase_car, race_active}), 32'b100);
        done_erase = 1;
        step();
        done_erase = 0;
        check("abort_stray_done", 32'({draw_bg, draw_car, erase_car, resetsignal, race_active}), 32'd0);
        step();
        check("abort_idle", 32'({draw_bg, draw_car, erase_car, resetsignal, race_active}), 32'd0);
        start = 1;
        ev_n = 0;
        service(20, 0, 0);
        check_events("reinit_draw", 2, mk(1,0,16,100), mk(1,1,48,100), '0, '0);

        run_frame(2'b00, 2'b00, 2'b10, 0, 0, 3);
        reset = 1;
        step();
        check("reset_midop", 32'(outvec()), 32'(o(0,0,0,2'd0,8'd16,7'd100,1,0,0,0)));
        reset = 0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/race_ctrl_multi.md
Name: race_ctrl_multi

Overview:
Parametrised race-sequencing FSM for the VGA racing game. It supports NUM_CARS independently steered cars.
- Owns every car's position registers.
- Sequences background draw and per-car erase/redraw through one shared pixel-drawer, using request/done handshakes.
- Detects the finish line and reports the winner.
It sits between the keyboard/button decode and the drawer datapath, and generalises the single-car control FSM.

Parameters:
NUM_CARS, 2, number of cars/players (1..4)
SEL_W, 2, width of car_sel/winner (>= clog2(NUM_CARS), min 1)
X_W, 8, x coordinate width
Y_W, 7, y coordinate width
X_MIN, 16, leftmost legal car x
X_MAX, 136, rightmost legal car x
X_STEP, 8, lateral step per press
LANE_SP, 32, start-x spacing between cars
Y_START, 100, start y for all cars; finish line is y == 0

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  level; race runs while high
btn_left  in  NUM_CARS  per-car left button, level
btn_right  in  NUM_CARS  per-car right button, level
btn_straight  in  NUM_CARS  per-car accelerate, level
frame_tick  in  1  one-cycle pulse per video frame
done_bg  in  1  drawer finished background (1-cycle pulse)
done_draw  in  1  drawer finished car sprite (pulse)
done_erase  in  1  drawer finished erase (pulse)
draw_bg  out  1  request background draw
draw_car  out  1  request sprite draw at car_x/car_y
erase_car  out  1  request erase at car_x/car_y
car_sel  out  SEL_W  car being drawn/erased
car_x  out  X_W  x of selected car
car_y  out  Y_W  y of selected car
resetsignal  out  1  1-cycle pulse to reset the menu/datapath
race_active  out  1  high in all race states
finished  out  1  high in FINISH
winner  out  SEL_W  winning car index, valid while finished
frame_overrun  out  1  1-cycle pulse when frame_tick is dropped

Behaviour:
- Reset:
  - State goes to RESET_SIG.
  - All requests, finished, winner and car_sel go to 0.
  - Car i is set to x = X_MIN + i*LANE_SP and y = Y_START.
  - Pending lateral moves are cleared.
- All outputs are registered Moore outputs except car_x/car_y, which are a mux of the position registers by car_sel.
- States:
  - RESET_SIG: resetsignal=1 for 1 cycle, then IDLE.
  - IDLE: wait for start=1. Positions reinitialised as at reset, then DRAW_BG.
  - DRAW_BG: draw_bg held high until done_bg, then DRAW_ALL with car_sel=0.
  - DRAW_ALL: draw_car held for each car_sel 0..NUM_CARS-1. Advance on done_draw; after the last car, go to WAIT_FRAME.
  - WAIT_FRAME: on frame_tick, snapshot move requests for every car, set car_sel=0, then SCAN.
  - SCAN: if car car_sel has a move, go to ERASE; else skip to the next car. After the last car, go to CHECK.
  - ERASE: erase_car held at the old position until done_erase, then UPDATE.
  - UPDATE (1 cycle): apply the move, then REDRAW.
  - REDRAW: draw_car at the new position until done_draw, then next car_sel to SCAN.
  - CHECK: if any y == 0, go to FINISH with winner = lowest such index; else WAIT_FRAME.
  - FINISH: finished=1; hold until start=0.
- Handshake:
  - A request goes high on state entry.
  - The FSM leaves its state in the cycle done is seen; the request is low the next cycle.
  - A done pulse arriving while no matching request is high is ignored.
- Move snapshot per car:
  - Lateral moves are rising-edge detected on registered buttons. A pending-left/pending-right flag accumulates between frames.
  - Both pending, or both buttons rising in the same cycle: no lateral move.
  - Straight is sampled as a level at frame_tick.
  - The car "has a move" if straight, or a lateral move is pending, and the resulting position differs from the current one.
- Arithmetic:
  - x saturates to [X_MIN, X_MAX] (left: max(x-X_STEP, X_MIN); right: min(x+X_STEP, X_MAX)).
  - y decrements by 1 if straight, never below 0.
  - Straight and lateral can apply in the same UPDATE.
- Pending flags are cleared at snapshot. Edges arriving after the snapshot belong to the next frame.
- frame_tick outside WAIT_FRAME is dropped and frame_overrun pulses that cycle.
- start=0 in any race state (DRAW_BG..CHECK, FINISH) goes to RESET_SIG next cycle, abandoning any handshake. A later done pulse is ignored.
- reset mid-operation has priority over everything.

Test Plan:
- Reset, start=1 with NUM_CARS=2 → resetsignal pulse, draw_bg until done_bg, then draw_car with car_sel=0 (x=16,y=100) and car_sel=1 (x=48,y=100), then WAIT_FRAME.
- Car0 straight held, frame_tick → erase at (16,100), redraw at (16,99); car1 untouched (no erase/draw with car_sel=1).
- Car1 three right presses over 3 frames from x=120 → x=128, 136, 136; the third frame has no erase/draw, because the clamped position is unchanged.
- Car0 left and right pressed in the same frame → no move. A frame_tick injected during REDRAW → frame_overrun=1 for 1 cycle, with the state unaffected.
- Both cars straight reaching y=0 in the same frame → finished=1, winner=0. Then start=0 → resetsignal pulse, IDLE.
- start dropped while erase_car is high → RESET_SIG next cycle. A later done_erase is ignored, and positions are reinitialised on the next start.
